dsram_arb: RTL and testbench

DSRAM_ARB -- requirements
Module: dsram_arb

---
 rtl/dsram_arb_pkg.sv | 26 ++
 rtl/dsram_arb_arb2_sel.sv | 48 ++++
 rtl/dsram_arb.sv | 176 +++++++++++++++++
 tb/tb_dsram_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_arb_pkg.sv
// ---------------------------------------------------------------------------
// dsram_arb_pkg
// Shared definitions for the data-SRAM arbiter: FSM state encoding, burst
// block geometry and a helper that forms wrapped burst beat addresses.
// Build option: DSRAM_ARB_RR_EN (used by arb2_sel / dsram_arb) selects
// round-robin instead of fixed p0 priority for IDLE conflicts.
// ---------------------------------------------------------------------------
package dsram_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // A burst walks the words of one aligned 32-byte block.
    localparam int BURST_BLK_WORDS = 8;
    localparam int BEAT_W          = $clog2(BURST_BLK_WORDS);

    // Word index inside the block for a given beat; wraps mod BURST_BLK_WORDS
    // because the result is only BEAT_W bits wide.
    function automatic logic [BEAT_W-1:0] beat_word(input logic [BEAT_W-1:0] start,
                                                    input logic [BEAT_W-1:0] beat);
        return start + beat;
    endfunction

endpackage

// File: rtl/dsram_arb_arb2_sel.sv
// ---------------------------------------------------------------------------
// arb2_sel
// Two-requester select used while the arbiter is in IDLE.
//   arb_en      : selection allowed this cycle (IDLE and not in reset)
//   req0, req1  : requests from p0 / p1
//   gnt0, gnt1  : one-hot (or zero) selection, combinational
// Build option DSRAM_ARB_RR_EN: round-robin, the last winner loses the next
// conflict; this variant adds clk/rst ports for its pointer. Without it p0
// has fixed priority and the block is purely combinational.
// ---------------------------------------------------------------------------
module arb2_sel (
`ifdef DSRAM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic arb_en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef DSRAM_ARB_RR_EN
    // favour1_q=1 means p1 wins the next conflict; reset favours p0.
    logic favour1_q;

    always_comb begin
        gnt0 = arb_en & req0 & ~(req1 & favour1_q);
        gnt1 = arb_en & req1 & ~(req0 & ~favour1_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            favour1_q <= 1'b0;
        end else if (gnt0) begin
            favour1_q <= 1'b1;
        end else if (gnt1) begin
            favour1_q <= 1'b0;
        end
    end
`else
    always_comb begin
        gnt0 = arb_en & req0;
        gnt1 = arb_en & req1 & ~req0;
    end
`endif

endmodule

// File: rtl/dsram_arb.sv
// ---------------------------------------------------------------------------
// dsram_arb
// Arbitrates one single-port data SRAM (1-cycle read latency) between the
// pipeline MEM stage (p0, single beats) and a secondary requester (p1, bursts
// of p1_len+1 beats wrapping inside an aligned 32-byte block).
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   p0_req/wen/addr/wdata            : p0 request (wen==0 is a read)
//   p0_gnt/rvalid/rdata              : p0 grant (combinational), read return
//   p1_req/wen/addr/wdata/len        : p1 request, len = beats minus 1
//   p1_gnt/rvalid/rdata/done         : p1 grant, read return, last-beat pulse
//   data_sram_en/wen/addr/wdata/rdata: SRAM port
//   fsm_state                        : current FSM state (debug observation)
// Handshake: a request is accepted in the cycle where req and gnt are both
// high; the requester holds req (and its payload) until it sees gnt. Read
// data returns with rvalid exactly one cycle after the accepting cycle.
// Build option: DSRAM_ARB_RR_EN selects round-robin IDLE arbitration.
// ---------------------------------------------------------------------------
module dsram_arb
    import dsram_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic [3:0]        p0_wen,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,

    input  logic              p1_req,
    input  logic [3:0]        p1_wen,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [2:0]        p1_len,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_done,

    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [31:0]       data_sram_wdata,
    input  logic [31:0]       data_sram_rdata,

    output state_e            fsm_state
);

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]         len_q;
    logic [3:0]         wen_q;
    logic [ADDR_W-1:2]  base_q;        // burst base word address
    logic               load_burst;
    logic               sel0, sel1;
    logic               rd0_q, rd1_q;
    logic [BEAT_W-1:0]  beat_idx;
    logic [ADDR_W-1:0]  burst_addr;

    arb2_sel u_sel (
`ifdef DSRAM_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .arb_en (state_q == ST_IDLE && !rst),
        .req0   (p0_req),
        .req1   (p1_req),
        .gnt0   (sel0),
        .gnt1   (sel1)
    );

    // Beat address: base block, word index advanced by the beat count and
    // wrapped inside the block, byte offset forced to zero.
    always_comb begin
        beat_idx   = beat_word(base_q[4:2], cnt_q);
        burst_addr = {base_q[ADDR_W-1:5], beat_idx, 2'b00};
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        load_burst      = 1'b0;
        p0_gnt          = 1'b0;
        p1_gnt          = 1'b0;
        p1_done         = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0;
        data_sram_addr  = '0;
        data_sram_wdata = 32'b0;

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (sel0) begin
                        p0_gnt          = 1'b1;
                        data_sram_en    = 1'b1;
                        data_sram_wen   = p0_wen;
                        data_sram_addr  = p0_addr;
                        data_sram_wdata = p0_wdata;
                    end else if (sel1) begin
                        p1_gnt          = 1'b1;
                        data_sram_en    = 1'b1;
                        data_sram_wen   = p1_wen;
                        data_sram_addr  = p1_addr;
                        data_sram_wdata = p1_wdata;
                        if (p1_len == 3'd0) begin
                            p1_done = 1'b1;
                        end else begin
                            load_burst = 1'b1;
                            cnt_d      = BEAT_W'(1);
                            state_d    = ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    // p1_req low stalls: no access and the counter holds.
                    if (p1_req) begin
                        p1_gnt          = 1'b1;
                        data_sram_en    = 1'b1;
                        data_sram_wen   = wen_q;
                        data_sram_addr  = burst_addr;
                        data_sram_wdata = p1_wdata;
                        if (cnt_q == len_q) begin
                            p1_done = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= 3'd0;
            wen_q   <= 4'b0;
            base_q  <= '0;
            rd0_q   <= 1'b0;
            rd1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_burst) begin
                len_q  <= p1_len;
                wen_q  <= p1_wen;
                base_q <= p1_addr[ADDR_W-1:2];
            end
            rd0_q <= p0_gnt && (data_sram_wen == 4'b0);
            rd1_q <= p1_gnt && (data_sram_wen == 4'b0);
        end
    end

    // Gating with rst drops a read that was in flight when reset arrived.
    always_comb begin
        p0_rvalid = rd0_q & ~rst;
        p1_rvalid = rd1_q & ~rst;
        p0_rdata  = p0_rvalid ? data_sram_rdata : 32'b0;
        p1_rdata  = p1_rvalid ? data_sram_rdata : 32'b0;
        fsm_state = state_q;
    end

endmodule

// File: tb/tb_dsram_arb.sv
module tb_dsram_arb;
    import dsram_arb_pkg::*;

    localparam int ADDR_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic              p0_req, p0_gnt, p0_rvalid;
    logic [3:0]        p0_wen;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wdata, p0_rdata;
    logic              p1_req, p1_gnt, p1_rvalid, p1_done;
    logic [3:0]        p1_wen;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wdata, p1_rdata;
    logic [2:0]        p1_len;
    logic              data_sram_en;
    logic [3:0]        data_sram_wen;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [31:0]       data_sram_wdata, data_sram_rdata;
    state_e            fsm_state;

    dsram_arb #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_len(p1_len), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_done(p1_done),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .fsm_state(fsm_state)
    );

    // ---------------- SRAM environment (1-cycle read latency) ----------------
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (data_sram_en) begin
            if (data_sram_wen == 4'b0) begin
                data_sram_rdata <= mem[data_sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (data_sram_wen[b])
                        mem[data_sram_addr[9:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];     // {port (0=p0,1=p1), read data}
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] beat_q[$];    // addresses of the burst beats still to come
    logic [3:0]  m_wen;
    bit          m_favour1;
    bit          pend_valid;
    logic [32:0] pend;

    // One clock: drive inputs after the edge, then compare combinational
    // outputs against the model and schedule any read response.
    task automatic cycle(input logic r,
                         input logic a_req, input logic [3:0] a_wen,
                         input logic [31:0] a_addr, input logic [31:0] a_wd,
                         input logic b_req, input logic [3:0] b_wen,
                         input logic [31:0] b_addr, input logic [31:0] b_wd,
                         input logic [2:0] b_len);
        logic e_g0, e_g1, e_done, e_en, w0, w1;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wd;
        logic [2:0]  bi;
        logic [7:0]  idx;
        @(posedge clk);
        #1;
        rst = r;
        p0_req = a_req; p0_wen = a_wen; p0_addr = a_addr; p0_wdata = a_wd;
        p1_req = b_req; p1_wen = b_wen; p1_addr = b_addr; p1_wdata = b_wd; p1_len = b_len;
        #1;
        e_g0 = 0; e_g1 = 0; e_done = 0; e_wen = 0; e_addr = 0; e_wd = 0;
        chk("fsm_state", 32'(fsm_state), (beat_q.size() > 0) ? 32'(ST_BURST) : 32'(ST_IDLE));
        if (r) begin
            beat_q.delete();
            m_favour1  = 0;
            pend_valid = 0;
        end else begin
            if (pend_valid) exp_q.push_back(pend);
            pend_valid = 0;
            if (beat_q.size() > 0) begin
                if (b_req) begin
                    e_g1   = 1;
                    e_addr = beat_q.pop_front();
                    e_wen  = m_wen;
                    e_wd   = b_wd;
                    e_done = (beat_q.size() == 0);
                end
            end else begin
`ifdef DSRAM_ARB_RR_EN
                w0 = a_req && !(b_req && m_favour1);
`else
                w0 = a_req;
`endif
                w1 = b_req && !w0;
                if (w0) begin
                    e_g0 = 1; e_wen = a_wen; e_addr = a_addr; e_wd = a_wd;
                    m_favour1 = 1;
                end else if (w1) begin
                    e_g1 = 1; e_wen = b_wen; e_addr = b_addr; e_wd = b_wd;
                    m_favour1 = 0;
                    if (b_len == 0) e_done = 1;
                    m_wen = b_wen;
                    for (int k = 1; k <= int'(b_len); k++) begin
                        bi = b_addr[4:2] + 3'(k);
                        beat_q.push_back({b_addr[31:5], bi, 2'b00});
                    end
                end
            end
        end
        e_en = e_g0 | e_g1;
        chk("p0_gnt", 32'(p0_gnt), 32'(e_g0));
        chk("p1_gnt", 32'(p1_gnt), 32'(e_g1));
        chk("p1_done", 32'(p1_done), 32'(e_done));
        chk("sram_en", 32'(data_sram_en), 32'(e_en));
        chk("sram_wen", 32'(data_sram_wen), 32'(e_wen));
        if (e_en) begin
            chk("sram_addr", data_sram_addr, e_addr);
            if (e_wen != 0) chk("sram_wdata", data_sram_wdata, e_wd);
            idx = e_addr[9:2];
            if (e_wen == 0) begin
                pend_valid = 1;
                pend = {e_g1, ref_mem[idx]};
            end else begin
                for (int b = 0; b < 4; b++)
                    if (e_wen[b]) ref_mem[idx][8*b +: 8] = e_wd[8*b +: 8];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        chk("rvalid_due", 32'(p0_rvalid | p1_rvalid), 32'(exp_q.size() > 0));
        if (p0_rvalid && p1_rvalid) begin
            checks++; errors++;
            $display("FAIL both_rvalid: got 1 1 expected at most one");
        end
        if ((p0_rvalid || p1_rvalid) && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid_port", 32'(p1_rvalid), 32'(e[32]));
            chk("rdata", p1_rvalid ? p1_rdata : p0_rdata, e[31:0]);
        end
        if (!p0_rvalid) chk("p0_rdata_zero", p0_rdata, 32'h0);
        if (!p1_rvalid) chk("p1_rdata_zero", p1_rdata, 32'h0);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        rst = 1'b1;
        p0_req = 0; p0_wen = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_wen = 0; p1_addr = 0; p1_wdata = 0; p1_len = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (32'(i) * 32'h9E3779B1) ^ 32'(i);
            ref_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'(i);
        end
        mem[8'h40]     = 32'hDEADBEEF;
        ref_mem[8'h40] = 32'hDEADBEEF;
        data_sram_rdata = 32'h0;
        m_favour1 = 0; pend_valid = 0; m_wen = 0; pend = 0;

        // reset with requests present: nothing may be granted
        cycle(1, 1, 0, 32'h100, 0, 1, 0, 32'h118, 0, 3'd3);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // p0 single read of 0xDEADBEEF
        cycle(0, 1, 4'h0, 32'h100, 0, 0, 0, 0, 0, 0);
        idle(1);

        // p1 wrapped read burst from 0x118, p0 requesting throughout
        cycle(0, 0, 0, 0, 0, 1, 4'h0, 32'h118, 0, 3'd3);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'h0, 32'h040, 0, 1, 4'h0, 32'h118, 0, 3'd3);
        cycle(0, 1, 4'h0, 32'h040, 0, 0, 0, 0, 0, 0);
        idle(1);

        // both requesting every cycle, single-beat p1
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 4'h0, 32'(4 * i), 0, 1, 4'h0, 32'(32'h80 + 4 * i), 0, 3'd0);
        idle(1);

        // p1 write burst, stall two cycles before the last beat, then read back
        cycle(0, 0, 0, 0, 0, 1, 4'hF, 32'h200, 32'h11111111, 3'd2);
        cycle(0, 0, 0, 0, 0, 1, 4'hF, 32'h200, 32'h22222222, 3'd2);
        cycle(0, 0, 0, 0, 0, 0, 4'hF, 32'h200, 32'h0BAD0BAD, 3'd2);
        cycle(0, 0, 0, 0, 0, 0, 4'hF, 32'h200, 32'h0BAD0BAD, 3'd2);
        cycle(0, 0, 0, 0, 0, 1, 4'hF, 32'h200, 32'h33333333, 3'd2);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'h0, 32'(32'h200 + 4 * i), 0, 0, 0, 0, 0, 0);
        idle(1);

        // reset on beat 1 of a len=7 read burst, then immediate p0 read
        cycle(0, 0, 0, 0, 0, 1, 4'h0, 32'h300, 0, 3'd7);
        cycle(1, 1, 4'h0, 32'h104, 0, 1, 4'h0, 32'h300, 0, 3'd7);
        cycle(0, 1, 4'h0, 32'h104, 0, 0, 0, 0, 0, 0);
        idle(1);

        // randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            ra = 32'($urandom_range(0, 255)) << 2;
            cycle(($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15)),
                  ra, $urandom,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15)),
                  32'($urandom_range(0, 255)) << 2, $urandom,
                  3'($urandom_range(0, 7)));
        end
        // let any burst finish, then drain
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 3'd0);
        idle(3);

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
